priority_irq_latch: RTL and testbench
=====================================

PRIORITY_IRQ_LATCH -- requirements
Module: priority_irq_latch

Interface
REQ-001 Parameter: n, default 6, number of request lines; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  n  level request lines, bit i = source i; higher index = higher priority.
REQ-005 Port: mask  input  n  1 = source excluded from selection; pending bit still kept.
REQ-006 Port: out_valid  output  1  registered; an index is presented.
REQ-007 Port: out_idx  output  $clog2(n)  registered; index of the presented source.
REQ-008 Port: out_ready  input  1  consumer accepts the presented index.
REQ-009 Port: pending  output  n  registered; latched, not-yet-served requests.
REQ-010 Port: overflow  output  1  registered sticky flag; a request event was lost.

Function
REQ-011 req shall be registered every cycle into req_q; event vector ev = req & ~req_q (rising-edge detect).
REQ-012 pending[i] shall set at the edge where ev[i]=1, independent of mask and FSM state.
REQ-013 Candidate vector cand = pending & ~mask; selection = highest set index of cand.
REQ-014 FSM states: IDLE, PRESENT; reset state IDLE.
REQ-015 IDLE -> PRESENT when cand != 0: out_idx <= selection, out_valid <= 1 at that edge.
REQ-016 IDLE with cand == 0: stay IDLE, out_valid = 0, out_idx holds its last value.
REQ-017 PRESENT: out_idx and out_valid shall stay stable until handshake, regardless of req, mask, or newer higher-priority pending bits.
REQ-018 Handshake = out_valid & out_ready at a rising edge: pending[out_idx] cleared, out_valid <= 0, PRESENT -> IDLE.
REQ-019 PRESENT with out_ready=0: hold; no timeout.
REQ-020 out_ready while out_valid=0 shall be ignored.
REQ-021 Throughput: at most one handshake per 2 cycles; IDLE always lasts at least one cycle between grants.
REQ-022 Latency: req first high at edge k -> pending set at edge k -> out_valid=1 after edge k+1, if FSM in IDLE and bit unmasked and highest.
REQ-023 Simultaneous ev[i] and handshake clearing bit i at the same edge: set wins; pending[i] stays 1.
REQ-024 ev[i] while pending[i]=1 and not cleared at that edge: event dropped; overflow <= 1.
REQ-025 overflow shall clear only on reset.
REQ-026 A level held high shall produce exactly one event until it drops low for at least one cycle.
REQ-027 Masking the presented source during PRESENT shall not withdraw it; handshake still clears it.
REQ-028 out_idx width is $clog2(n); values >= n shall never be produced.

Reset
REQ-029 rst_n=0 shall immediately force: state IDLE, out_valid=0, out_idx=0, pending=0, overflow=0, req_q=0.
REQ-030 Reset mid-PRESENT abandons the presented index with no handshake; cleared pending bits are lost.
REQ-031 req held high across reset release shall produce one event at the first edge after release (req_q=0).

Verification (n=6)
REQ-032 Reset, req=6'b000100, mask=0, ready=1 -> pending=6'b000100 after edge 1; out_valid=1, out_idx=2 after edge 2; pending=0, out_valid=0 after edge 3.
REQ-033 req=6'b100101 in one cycle, ready=1 -> out_idx sequence 5, 2, 0 on successive grants, 2 cycles apart; pending ends 0.
REQ-034 Presenting idx=1, ready=0, then req[4] rises and mask=6'b000010 -> out_idx stays 1 until ready=1; next grant is 4.
REQ-035 req[3] pulses, drops, pulses again before service -> overflow=1, one grant for idx 3, overflow remains 1 until reset.
REQ-036 Handshake on idx 0 at same edge as new req[0] rising -> pending[0] stays 1; idx 0 presented again 2 cycles later; overflow=0.
REQ-037 Assert rst_n=0 mid-PRESENT with pending=6'b011000 -> all outputs 0 immediately; req held 6'b001000 across release -> pending=6'b001000 after first edge.

Source files
------------

// File: rtl/priority_irq_latch.sv
// Edge-detecting interrupt latch with a fixed-priority selector and a
// two-state present/handshake FSM; higher request index wins.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | nothing presented; grant highest unmasked pending source
// ST_PRESENT | out_idx/out_valid frozen until out_ready handshake
module priority_irq_latch #(
   parameter int n = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [n-1:0]         req,
   input  logic [n-1:0]         mask,
   output logic                 out_valid,
   output logic [$clog2(n)-1:0] out_idx,
   input  logic                 out_ready,
   output logic [n-1:0]         pending,
   output logic                 overflow
);

   localparam int IW = $clog2(n);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [n-1:0]    req_q, req_d;
   logic [n-1:0]    pending_q, pending_d;
   logic            overflow_q, overflow_d;
   logic            out_valid_q, out_valid_d;
   logic [IW-1:0]   out_idx_q, out_idx_d;

   logic [n-1:0]    ev;
   logic [n-1:0]    cand;
   logic [n-1:0]    clr;
   logic            handshake;
   logic            sel_valid;
   logic [IW-1:0]   sel_idx;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         req_q       <= '0;
         pending_q   <= '0;
         overflow_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         pending_q   <= pending_d;
         overflow_q  <= overflow_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
      end
   end

   // ------------------------------------------------------------------
   // Event detect, pending bookkeeping and priority select
   // ------------------------------------------------------------------
   always_comb begin
      req_d     = req;
      ev        = req & ~req_q;
      handshake = out_valid_q & out_ready;
      cand      = pending_q & ~mask;

      clr = '0;
      for (int i = 0; i < n; i++) begin
         clr[i] = handshake && (out_idx_q == IW'(i));
      end

      // An event on a bit that is still pending (and not being served
      // this edge) is lost; a same-edge clear and set leaves it pending.
      overflow_d = overflow_q | (|(ev & pending_q & ~clr));
      pending_d  = (pending_q & ~clr) | ev;

      sel_valid = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < n; i++) begin
         if (cand[i]) begin
            sel_valid = 1'b1;
            sel_idx   = IW'(i);
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_valid) state_d = ST_PRESENT;
         end
         ST_PRESENT: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   always_comb begin
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      case (state_q)
         ST_IDLE: begin
            out_valid_d = sel_valid;
            if (sel_valid) out_idx_d = sel_idx;
         end
         ST_PRESENT: begin
            if (out_ready) out_valid_d = 1'b0;
         end
         default: out_valid_d = 1'b0;
      endcase
   end

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign pending   = pending_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_priority_irq_latch.sv
// Directed scenarios plus a randomized run, each edge checked against a
// per-source behavioural model of the interrupt latch.
module tb_priority_irq_latch;

   localparam int N  = 6;
   localparam int IW = $clog2(N);

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [N-1:0]  mask;
   logic          out_ready;
   logic          out_valid;
   logic [IW-1:0] out_idx;
   logic [N-1:0]  pending;
   logic          overflow;

   int n_cmp;
   int n_err;

   // model state
   bit m_prev [N];
   bit m_pend [N];
   bit m_valid;
   int m_idx;
   bit m_ovf;

   priority_irq_latch #(.n(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mask      (mask),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .out_ready (out_ready),
      .pending   (pending),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] model_pend_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_prev[i] = 1'b0;
         m_pend[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_idx   = 0;
      m_ovf   = 1'b0;
   endtask

   // One rising edge of the model, evaluated with the inputs as sampled.
   task automatic model_step();
      bit served [N];
      bit old_pend [N];
      int best;
      for (int i = 0; i < N; i++) begin
         old_pend[i] = m_pend[i];
         served[i]   = m_valid && out_ready && (m_idx == i);
      end
      for (int i = 0; i < N; i++) begin
         bit rise;
         rise = req[i] && !m_prev[i];
         if (served[i]) m_pend[i] = 1'b0;
         if (rise) begin
            if (old_pend[i] && !served[i]) m_ovf = 1'b1;
            m_pend[i] = 1'b1;
         end
         m_prev[i] = req[i];
      end
      if (m_valid) begin
         if (out_ready) m_valid = 1'b0;
      end else begin
         best = -1;
         for (int i = N - 1; i >= 0; i--) begin
            if (best < 0 && old_pend[i] && !mask[i]) best = i;
         end
         if (best >= 0) begin
            m_valid = 1'b1;
            m_idx   = best;
         end
      end
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, ".valid"},   32'(out_valid), 32'(m_valid));
      chk({tag, ".idx"},     32'(out_idx),   32'(m_idx));
      chk({tag, ".pending"}, 32'(pending),   32'(model_pend_vec()));
      chk({tag, ".ovf"},     32'(overflow),  32'(m_ovf));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      cmp_model(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      model_reset();
      cmp_model("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      rst_n     = 1'b1;
      req       = '0;
      mask      = '0;
      out_ready = 1'b0;
      model_reset();
      #2;

      // Single request, full latency trace
      do_reset();
      req = 6'b000100; mask = '0; out_ready = 1'b1;
      tick("s1.e1");
      chk("s1.pend_e1",  32'(pending),   32'h04);
      chk("s1.valid_e1", 32'(out_valid), 32'h0);
      tick("s1.e2");
      chk("s1.valid_e2", 32'(out_valid), 32'h1);
      chk("s1.idx_e2",   32'(out_idx),   32'h2);
      req = '0;
      tick("s1.e3");
      chk("s1.pend_e3",  32'(pending),   32'h0);
      chk("s1.valid_e3", 32'(out_valid), 32'h0);

      // Three simultaneous requests served in priority order
      do_reset();
      req = 6'b100101; out_ready = 1'b1;
      tick("s2.e1");
      req = '0;
      tick("s2.e2");
      chk("s2.grant5", 32'(out_idx), 32'h5);
      tick("s2.e3");
      tick("s2.e4");
      chk("s2.grant2", 32'(out_idx), 32'h2);
      tick("s2.e5");
      tick("s2.e6");
      chk("s2.grant0", 32'(out_idx), 32'h0);
      tick("s2.e7");
      chk("s2.pend_end", 32'(pending), 32'h0);

      // Presented index frozen against newer higher priority and masking
      do_reset();
      out_ready = 1'b0;
      req = 6'b000010;
      tick("s3.e1");
      req = '0;
      tick("s3.e2");
      req = 6'b010000; mask = 6'b000010;
      tick("s3.e3");
      tick("s3.e4");
      tick("s3.e5");
      chk("s3.hold_idx",   32'(out_idx),   32'h1);
      chk("s3.hold_valid", 32'(out_valid), 32'h1);
      out_ready = 1'b1;
      tick("s3.hs");
      out_ready = 1'b0;
      tick("s3.next");
      chk("s3.next_idx", 32'(out_idx), 32'h4);
      mask = '0; req = '0;

      // Re-pulse before service loses an event, overflow sticks
      do_reset();
      out_ready = 1'b0;
      req = 6'b001000;
      tick("s4.e1");
      req = '0;
      tick("s4.e2");
      req = 6'b001000;
      tick("s4.e3");
      chk("s4.ovf_set", 32'(overflow), 32'h1);
      req = '0; out_ready = 1'b1;
      tick("s4.hs");
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) tick("s4.idle");
      chk("s4.no_regrant", 32'(out_valid), 32'h0);
      chk("s4.ovf_stuck",  32'(overflow),  32'h1);

      // Same-edge handshake and new event on bit 0
      do_reset();
      out_ready = 1'b0;
      req = 6'b000001;
      tick("s5.e1");
      req = '0;
      tick("s5.e2");
      req = 6'b000001; out_ready = 1'b1;
      tick("s5.hs");
      chk("s5.pend_kept", 32'(pending[0]), 32'h1);
      out_ready = 1'b0;
      tick("s5.regrant");
      chk("s5.valid", 32'(out_valid), 32'h1);
      chk("s5.idx",   32'(out_idx),   32'h0);
      chk("s5.ovf",   32'(overflow),  32'h0);
      req = '0;

      // Reset while presenting, request held across release
      do_reset();
      out_ready = 1'b0;
      req = 6'b011000;
      tick("s6.e1");
      tick("s6.e2");
      chk("s6.pend_pre", 32'(pending), 32'h18);
      req = 6'b001000;
      do_reset();
      chk("s6.rst_valid", 32'(out_valid), 32'h0);
      chk("s6.rst_pend",  32'(pending),   32'h0);
      tick("s6.rel");
      chk("s6.pend_rel", 32'(pending), 32'h08);

      // Randomized traffic
      do_reset();
      req = '0; mask = '0;
      for (int k = 0; k < 400; k++) begin
         req = req ^ N'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 7) == 0) mask = N'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         tick("rnd");
         if ($urandom_range(0, 150) == 0) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
